fantasticfft_fft8_ctrl: RTL and testbench
=========================================

Name: fantasticfft_fft8_ctrl

Overview:
- Frame sequencer for the 8-point FFT datapath.
- Collects a serial stream of real samples into an 8-slot frame and presents it in parallel to the FFT core's x0..x7.
- Waits the core's pipeline latency, captures y0..y7, then streams the 8 results out serially with valid/ready handshakes.
- Sits between the sample source and the FFT core. It is the only block that drives the core's inputs.

Parameters:
- INPUT_SIZE, 8, sample and result width in bits; matches the core.
- LATENCY, 1, number of register stages in the FFT core, from x change to y settled; legal range 0..15.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous reset, active-high.
- in_valid  in  1  source offers in_data.
- in_ready  out  1  controller accepts in_data this cycle.
- in_data  in  INPUT_SIZE  sample, signed two's complement.
- fft_x  out  8*INPUT_SIZE  frame to core; slot k at bits [k*INPUT_SIZE +: INPUT_SIZE], wired to xk.
- fft_y  in  8*INPUT_SIZE  core results; slot k from yk, same packing.
- out_valid  out  1  out_data holds a result.
- out_ready  in  1  sink accepts out_data.
- out_data  out  INPUT_SIZE  result slot ocnt.
- out_last  out  1  high with out_valid on slot 7.
- busy  out  1  a frame is in progress.
- frames_done  out  16  count of fully drained frames; wraps at 65535 -> 0.

Behaviour:
- States: FILL, WAIT, DRAIN. All state is registered and uses the asynchronous reset.
- Reset (async assert) sets:
  - state=FILL, cnt=0, wcnt=0, ocnt=0.
  - All 8 sample registers = 0 and all 8 result registers = 0.
  - frames_done=0.
  - Outputs: in_ready=1, out_valid=0, out_last=0, out_data=0, busy=0, fft_x=0.
- in_ready = (state==FILL). It is combinational from state and has no dependency on in_valid.
- out_valid = (state==DRAIN). out_data = result[ocnt]. out_last = out_valid && ocnt==7.
- busy = (state!=FILL) || (cnt!=0).
- FILL:
  - On in_valid && in_ready, sample[cnt] <= in_data and cnt increments.
  - When slot 7 is accepted (edge E): cnt <= 0, wcnt <= 0, state <= WAIT.
  - in_valid low holds all state; gaps between samples are allowed.
- fft_x continuously reflects the sample registers. Slots change only on accepted writes.
- WAIT:
  - in_ready=0. wcnt increments each cycle.
  - When wcnt==LATENCY, result[k] <= fft_y slot k for all k, ocnt <= 0, state <= DRAIN.
  - Capture therefore happens at edge E+LATENCY+1. For LATENCY=0 that is edge E+1.
  - The core's own registers (no enable) are clocked every cycle. The sample registers are frozen through WAIT, so fft_y is stable at capture.
- DRAIN:
  - On out_valid && out_ready, ocnt increments.
  - When out_ready is low, out_data and out_last are held stable.
  - The slot-7 handshake causes: state <= FILL, ocnt <= 0, frames_done increments; in_ready is 1 from the next cycle.
- Sample registers are not cleared between frames; the next frame overwrites them slot by slot.
- Minimum frame period with no stalls: 8 + (LATENCY+1) + 8 cycles.
- No arithmetic on the data path; values pass through bit-exact. Only the counters use arithmetic:
  - cnt and ocnt: 3 bits.
  - wcnt: 4 bits.
  - frames_done: 16 bits, modulo 2^16.
- Mid-operation reset returns to FILL immediately. Any partial frame, pending capture or undrained results are discarded, and no out_valid is produced for them.
- Unsupported: samples offered while in_ready=0 are not taken; the source must hold them.

Test Plan:
- Reset then 8 back-to-back samples 1,2,...,8, core stub y=x+0x10 (LATENCY=1), out_ready=1 -> in_ready low on the cycle after the 8th; capture 2 cycles after edge E; outputs 0x11..0x18 in order; out_last only on 0x18; frames_done=1.
- Same frame with in_valid toggling every other cycle -> exactly 8 samples stored, in order. fft_x slot 3 = 4 once the 4th is accepted.
- DRAIN with out_ready low for 5 cycles at slot 2 -> out_valid stays 1, out_data stays 0x13 throughout, then the remaining slots follow. No slot is duplicated or skipped.
- LATENCY=0 and LATENCY=15 with a registered stub delaying y by LATENCY -> captured results equal the stub's settled values; WAIT lasts 1 and 16 cycles respectively.
- Assert rst after 5 samples (and separately during DRAIN at slot 4) -> all outputs return to reset values within the same cycle. A fresh frame 0x80..0x87 then produces exactly 8 correct results with no stale data, and frames_done counts only completed frames.
- Preload to 65535 completed frames (force or run) and drain one more -> frames_done wraps to 0.

Source files
------------

// File: rtl/fantasticfft_fft8_ctrl.sv
//============================================================================
// Module   : fantasticfft_fft8_ctrl
// Brief    : Frame sequencer for the 8-point FFT core. Gathers 8 serial
//            samples, holds them on the core inputs, captures the results
//            after the core latency and streams them out with valid/ready.
// Revision : 1.0 - initial release
//============================================================================
`default_nettype none

module fantasticfft_fft8_ctrl #(
    parameter int INPUT_SIZE = 8,
    parameter int LATENCY    = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [INPUT_SIZE-1:0]   in_data,
    output logic [8*INPUT_SIZE-1:0] fft_x,
    input  logic [8*INPUT_SIZE-1:0] fft_y,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [INPUT_SIZE-1:0]   out_data,
    output logic                    out_last,
    output logic                    busy,
    output logic [15:0]             frames_done
);

    typedef enum logic [1:0] {
        S_FILL  = 2'd0,
        S_WAIT  = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    localparam logic [3:0] c_lat = 4'(LATENCY);

    state_t                 r_state;
    logic [2:0]             r_cnt;
    logic [2:0]             r_ocnt;
    logic [3:0]             r_wcnt;
    logic [INPUT_SIZE-1:0]  r_sample [8];
    logic [INPUT_SIZE-1:0]  r_result [8];
    logic [15:0]            r_frames_done;

    logic                   w_in_fire;
    logic                   w_out_fire;

    assign w_in_fire  = in_valid  && (r_state == S_FILL);
    assign w_out_fire = out_ready && (r_state == S_DRAIN);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= S_FILL;
            r_cnt         <= 3'd0;
            r_ocnt        <= 3'd0;
            r_wcnt        <= 4'd0;
            r_frames_done <= 16'd0;
            for (int k = 0; k < 8; k++) begin
                r_sample[k] <= '0;
                r_result[k] <= '0;
            end
        end else begin
            case (r_state)
                S_FILL: begin
                    if (w_in_fire) begin
                        r_sample[r_cnt] <= in_data;
                        if (r_cnt == 3'd7) begin
                            r_cnt   <= 3'd0;
                            r_wcnt  <= 4'd0;
                            r_state <= S_WAIT;
                        end else begin
                            r_cnt <= r_cnt + 3'd1;
                        end
                    end
                end
                S_WAIT: begin
                    // Sample registers are frozen here, so fft_y is settled once wcnt reaches the latency.
                    r_wcnt <= r_wcnt + 4'd1;
                    if (r_wcnt == c_lat) begin
                        for (int k = 0; k < 8; k++) begin
                            r_result[k] <= fft_y[k*INPUT_SIZE +: INPUT_SIZE];
                        end
                        r_ocnt  <= 3'd0;
                        r_state <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (w_out_fire) begin
                        if (r_ocnt == 3'd7) begin
                            r_ocnt        <= 3'd0;
                            r_frames_done <= r_frames_done + 16'd1;
                            r_state       <= S_FILL;
                        end else begin
                            r_ocnt <= r_ocnt + 3'd1;
                        end
                    end
                end
                default: begin
                    r_state <= S_FILL;
                end
            endcase
        end
    end

    for (genvar k = 0; k < 8; k++) begin : g_slot
        assign fft_x[k*INPUT_SIZE +: INPUT_SIZE] = r_sample[k];
    end

    assign in_ready    = (r_state == S_FILL);
    assign out_valid   = (r_state == S_DRAIN);
    assign out_data    = r_result[r_ocnt];
    assign out_last    = (r_state == S_DRAIN) && (r_ocnt == 3'd7);
    assign busy        = (r_state != S_FILL) || (r_cnt != 3'd0);
    assign frames_done = r_frames_done;

endmodule

`default_nettype wire

// File: tb/tb_fantasticfft_fft8_ctrl.sv
//============================================================================
// Module   : tb_fantasticfft_fft8_ctrl
// Brief    : Bench for the FFT frame sequencer; three lanes with core stubs
//            of latency 1, 0 and 15 (stub y = x + 0x10 per slot).
// Revision : 1.0 - initial release
//============================================================================
`default_nettype none

module tb_fantasticfft_fft8_ctrl;

    localparam int W  = 8;
    localparam int NL = 3;

    logic              clk;
    logic              rst;
    logic [NL-1:0]     iv;
    logic [NL-1:0]     ir;
    logic [NL*W-1:0]   id;
    logic [NL*8*W-1:0] fx;
    logic [NL*8*W-1:0] fy;
    logic [NL-1:0]     ov;
    logic [NL-1:0]     ordy;
    logic [NL*W-1:0]   od;
    logic [NL-1:0]     ol;
    logic [NL-1:0]     bsy;
    logic [NL*16-1:0]  fd;

    int          n_chk;
    int          n_fail;
    logic [8:0]  exp_q[$];
    logic [15:0] fd_exp [NL];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int lat_of(input int i);
        return (i == 0) ? 1 : ((i == 1) ? 0 : 15);
    endfunction

    for (genvar i = 0; i < NL; i++) begin : g_lane
        localparam int L = (i == 0) ? 1 : ((i == 1) ? 0 : 15);
        logic [8*W-1:0] w_sum;
        for (genvar k = 0; k < 8; k++) begin : g_add
            assign w_sum[k*W +: W] = fx[i*8*W + k*W +: W] + 8'h10;
        end
        if (L == 0) begin : g_comb
            assign fy[i*8*W +: 8*W] = w_sum;
        end else begin : g_pipe
            logic [8*W-1:0] r_pipe [L];
            always @(posedge clk) begin
                r_pipe[0] <= w_sum;
                for (int j = 1; j < L; j++) r_pipe[j] <= r_pipe[j-1];
            end
            assign fy[i*8*W +: 8*W] = r_pipe[L-1];
        end

        fantasticfft_fft8_ctrl #(.INPUT_SIZE(W), .LATENCY(L)) u_dut (
            .clk        (clk),
            .rst        (rst),
            .in_valid   (iv[i]),
            .in_ready   (ir[i]),
            .in_data    (id[i*W +: W]),
            .fft_x      (fx[i*8*W +: 8*W]),
            .fft_y      (fy[i*8*W +: 8*W]),
            .out_valid  (ov[i]),
            .out_ready  (ordy[i]),
            .out_data   (od[i*W +: W]),
            .out_last   (ol[i]),
            .busy       (bsy[i]),
            .frames_done(fd[i*16 +: 16])
        );
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Scoreboard: every handshaken output is matched against the queue head.
    always @(negedge clk) begin
        if (!rst) begin
            for (int i = 0; i < NL; i++) begin
                if (ov[i] && ordy[i]) begin
                    chk("out_pending", 32'(exp_q.size() != 0), 32'd1);
                    if (exp_q.size() != 0) begin
                        chk("out_word", 32'({ol[i], od[i*W +: W]}), 32'(exp_q[0]));
                        void'(exp_q.pop_front());
                    end
                end
            end
        end
    end

    // Entered and left at posedge+2; rst rises mid-cycle.
    task automatic do_reset();
        #1 rst = 1'b1;
        iv   = '0;
        ordy = '0;
        #1;
        for (int i = 0; i < NL; i++) begin
            chk("rst_in_ready",  32'(ir[i]),  32'd1);
            chk("rst_out_valid", 32'(ov[i]),  32'd0);
            chk("rst_out_last",  32'(ol[i]),  32'd0);
            chk("rst_out_data",  32'(od[i*W +: W]), 32'd0);
            chk("rst_busy",      32'(bsy[i]), 32'd0);
            chk("rst_fft_x_lo",  fx[i*8*W +: 32], 32'd0);
            chk("rst_fft_x_hi",  fx[i*8*W + 32 +: 32], 32'd0);
            chk("rst_frames",    32'(fd[i*16 +: 16]), 32'd0);
            fd_exp[i] = 16'd0;
        end
        exp_q.delete();
        @(posedge clk);
        #2 rst = 1'b0;
    endtask

    task automatic send(input int L, input logic [7:0] base, input int n, input bit gaps);
        int  k;
        int  budget;
        bit  tgl;
        bit  acc;
        k = 0; budget = 0; tgl = 1'b0;
        while (k < n && budget < 200) begin
            if (gaps && tgl) begin
                iv[L] = 1'b0;
            end else begin
                iv[L] = 1'b1;
                id[L*W +: W] = base + 8'(k);
            end
            tgl = !tgl;
            acc = iv[L] && ir[L];
            @(posedge clk);
            #2;
            if (acc) begin
                exp_q.push_back({(k == 7), base + 8'(k) + 8'h10});
                if (k == 3) chk("fft_x_slot3", 32'(fx[L*8*W + 3*W +: W]), 32'(base + 8'd3));
                if (k == 7) begin
                    chk("in_ready_after_e", 32'(ir[L]), 32'd0);
                    chk("busy_wait", 32'(bsy[L]), 32'd1);
                end
                k++;
            end
            budget++;
        end
        iv[L] = 1'b0;
        chk("samples_taken", 32'(k), 32'(n));
    endtask

    task automatic drain(input int L, input int stall_slot, input int stall_cycles, input int abort_at);
        int  w;
        int  j;
        int  st;
        int  b;
        bit  fire;
        bit  aborted;
        w = 0; j = 0; st = 0; b = 0; aborted = 1'b0;
        while (!ov[L] && w < 40) begin
            w++;
            @(posedge clk);
            #2;
        end
        chk("wait_len", 32'(w), 32'(lat_of(L) + 1));
        while (j < 8 && b < 100 && !aborted) begin
            if (j == abort_at) begin
                do_reset();
                aborted = 1'b1;
            end else begin
                if (j == stall_slot && st < stall_cycles) begin
                    ordy[L] = 1'b0;
                    st++;
                    chk("stall_valid", 32'(ov[L]), 32'd1);
                    chk("stall_data", 32'(od[L*W +: W]),
                        32'((exp_q.size() != 0) ? exp_q[0][7:0] : 8'hxx));
                end else begin
                    ordy[L] = 1'b1;
                end
                fire = ordy[L] && ov[L];
                @(posedge clk);
                #2;
                if (fire) j++;
                b++;
            end
        end
        ordy[L] = 1'b0;
        if (!aborted) begin
            fd_exp[L] = fd_exp[L] + 16'd1;
            chk("drained", 32'(j), 32'd8);
            chk("frames_done", 32'(fd[L*16 +: 16]), 32'(fd_exp[L]));
            chk("in_ready_refill", 32'(ir[L]), 32'd1);
            chk("busy_idle", 32'(bsy[L]), 32'd0);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        n_chk  = 0;
        n_fail = 0;
        rst    = 1'b0;
        iv     = '0;
        ordy   = '0;
        id     = '0;
        for (int i = 0; i < NL; i++) fd_exp[i] = 16'd0;
        @(posedge clk);
        #2;
        do_reset();

        // Back-to-back frame, then gapped frame, then a stalled drain.
        send(0, 8'h01, 8, 1'b0);
        drain(0, 8, 0, 8);
        send(0, 8'h01, 8, 1'b1);
        drain(0, 8, 0, 8);
        send(0, 8'h01, 8, 1'b0);
        drain(0, 2, 5, 8);

        // Latency extremes.
        send(1, 8'h40, 8, 1'b0);
        drain(1, 8, 0, 8);
        send(2, 8'h60, 8, 1'b1);
        drain(2, 3, 2, 8);

        // Reset after a partial fill.
        send(0, 8'h20, 5, 1'b0);
        chk("busy_partial", 32'(bsy[0]), 32'd1);
        do_reset();
        send(0, 8'h80, 8, 1'b0);
        drain(0, 8, 0, 8);

        // Reset in the middle of draining.
        send(0, 8'h30, 8, 1'b0);
        drain(0, 8, 0, 4);
        send(0, 8'h80, 8, 1'b0);
        drain(0, 8, 0, 8);

        // Frame counter wrap.
        force g_lane[0].u_dut.r_frames_done = 16'hffff;
        @(posedge clk);
        #2;
        release g_lane[0].u_dut.r_frames_done;
        chk("frames_preload", 32'(fd[15:0]), 32'h0000ffff);
        fd_exp[0] = 16'hffff;
        send(0, 8'hf8, 8, 1'b0);
        drain(0, 8, 0, 8);
        chk("frames_wrap", 32'(fd[15:0]), 32'd0);

        repeat (3) @(posedge clk);
        #2;
        chk("queue_empty", 32'(exp_q.size()), 32'd0);
        chk("no_valid_idle", 32'(ov), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
